// File: rtl/encap_packet.sv
// DFX word to Aurora frame serialiser: one {addr,data} word becomes NUM_FRAMES
// frames of {payload chunk, 9-bit header}. Optional macro ENCAP_PARITY_EN adds even parity in header bit 0.
module encap_packet #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_send,
  input  logic                         valid_dfx_send,
  output logic                         ready_dfx_send,
  output logic [AURORA_DATA_WIDTH-1:0] data_out_dfx,
  output logic                         valid_out_dfx,
  input  logic                         tx_tready,
  output logic                         done_encap_pkt
);

  localparam int HDR_WIDTH   = 9;
  localparam int CHUNK_WIDTH = AURORA_DATA_WIDTH - HDR_WIDTH;
  localparam int NUM_FRAMES  = (DATA_DFX_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int PAD_WIDTH   = NUM_FRAMES * CHUNK_WIDTH;
  localparam logic [4:0] LAST_IDX = 5'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                        state, state_next;
  logic [DATA_DFX_WIDTH-1:0]     pkt_reg;
  logic [4:0]                    frame_cnt;
  logic [PAD_WIDTH-1:0]          pkt_pad;
  logic [CHUNK_WIDTH-1:0]        chunk;
  logic [AURORA_DATA_WIDTH-2:0]  frame_body;
  logic                          par_bit;
  logic                          accept;
  logic                          xfer;
  logic                          last_frame;

  // The final frame's unused upper payload bits come out as zero via this padding.
  assign pkt_pad    = {{(PAD_WIDTH - DATA_DFX_WIDTH){1'b0}}, pkt_reg};
  assign chunk      = pkt_pad[int'(frame_cnt) * CHUNK_WIDTH +: CHUNK_WIDTH];
  assign frame_body = {chunk, frame_cnt, (frame_cnt == 5'd0), (frame_cnt == LAST_IDX), 1'b0};

`ifdef ENCAP_PARITY_EN
  assign par_bit = ^frame_body;
`else
  assign par_bit = 1'b0;
`endif

  assign accept     = valid_dfx_send && ready_dfx_send;
  assign xfer       = valid_out_dfx && tx_tready;
  assign last_frame = (frame_cnt == LAST_IDX);

  always_comb begin
    state_next     = state;
    ready_dfx_send = 1'b0;
    valid_out_dfx  = 1'b0;
    done_encap_pkt = 1'b0;
    data_out_dfx   = '0;
    case (state)
      IDLE: begin
        ready_dfx_send = 1'b1;
        if (valid_dfx_send) state_next = SEND;
      end
      SEND: begin
        valid_out_dfx = 1'b1;
        data_out_dfx  = {frame_body, par_bit};
        if (tx_tready && last_frame) state_next = DONE;
      end
      DONE: begin
        done_encap_pkt = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state: reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= 5'd0;
    end else begin
      state <= state_next;
      if (state != SEND)
        frame_cnt <= 5'd0;
      else if (xfer && !last_frame)
        frame_cnt <= frame_cnt + 5'd1;
    end
  end

  // Payload capture; only written on accept so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) pkt_reg <= data_dfx_send;
  end

endmodule

// File: tb/tb_encap_packet.sv
// Scoreboard bench for encap_packet: expected frames queued at accept, compared at transfer.
module tb_encap_packet;

  localparam int DW = 1034;
  localparam int CW = 55;
  localparam int NF = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_dfx_send = '0;
  logic          valid_dfx_send = 1'b0;
  logic          ready_dfx_send;
  logic [63:0]   data_out_dfx;
  logic          valid_out_dfx;
  logic          tx_tready = 1'b1;
  logic          done_encap_pkt;

  encap_packet dut (
    .clk            (clk),
    .rst            (rst),
    .data_dfx_send  (data_dfx_send),
    .valid_dfx_send (valid_dfx_send),
    .ready_dfx_send (ready_dfx_send),
    .data_out_dfx   (data_out_dfx),
    .valid_out_dfx  (valid_out_dfx),
    .tx_tready      (tx_tready),
    .done_encap_pkt (done_encap_pkt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_frame(input logic [DW-1:0] w, input int j);
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < CW; k++) begin
      if (j * CW + k < DW) f[9 + k] = w[j * CW + k];
    end
    f[8:4] = 5'(j);
    f[3]   = (j == 0);
    f[2]   = (j == NF - 1);
`ifdef ENCAP_PARITY_EN
    f[0] = ^f[63:1];
`endif
    return f;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i += 32) begin
      logic [31:0] r;
      r = $urandom;
      for (int b = 0; b < 32; b++) if (i + b < DW) w[i + b] = r[b];
    end
    return w;
  endfunction

  logic [63:0]        exp_q[$];
  logic [DW-1:0]      sent_q[$];
  logic [NF*CW-1:0]   rx_pad;
  int acc_cnt = 0, acc_cyc = 0, xfer_cnt = 0, done_cnt = 0, done_cyc = 0;
  int sof_cyc = 0, eof_cyc = 0;
  logic [8:0]  sof_hdr, eof_hdr;
  logic        prev_stall = 1'b0, prev_eof_xfer = 1'b0, prev_done = 1'b0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_dfx_send && ready_dfx_send) begin
        for (int j = 0; j < NF; j++) exp_q.push_back(model_frame(data_dfx_send, j));
        sent_q.push_back(data_dfx_send);
        acc_cyc = cyc;
        acc_cnt++;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(valid_out_dfx), 64'd1);
        check("stall_data", data_out_dfx, prev_data);
      end
      if (valid_out_dfx && tx_tready) begin
        int j;
        check("frame_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("frame", data_out_dfx, exp_q.pop_front());
`ifdef ENCAP_PARITY_EN
        check("parity_even", 64'(^data_out_dfx), 64'd0);
        check("parity_flip20", 64'(^(data_out_dfx ^ (64'd1 << 20))), 64'd1);
`endif
        j = int'(data_out_dfx[8:4]);
        for (int k = 0; k < CW; k++) if (j < NF) rx_pad[j * CW + k] = data_out_dfx[9 + k];
        if (data_out_dfx[3]) begin sof_cyc = cyc; sof_hdr = data_out_dfx[8:0]; end
        if (data_out_dfx[2]) begin
          eof_cyc = cyc;
          eof_hdr = data_out_dfx[8:0];
          check("rx_q_nonempty", 64'(sent_q.size() > 0), 64'd1);
          if (sent_q.size() > 0)
            check("rx_word_diff_bits", 64'($countones(rx_pad[DW-1:0] ^ sent_q.pop_front())), 64'd0);
        end
        xfer_cnt++;
      end
      if (done_encap_pkt) begin
        check("done_after_eof", 64'(prev_eof_xfer), 64'd1);
        check("done_valid_low", 64'(valid_out_dfx), 64'd0);
        check("done_ready_low", 64'(ready_dfx_send), 64'd0);
        done_cyc = cyc;
        done_cnt++;
      end
      if (prev_done) check("done_width", 64'(done_encap_pkt), 64'd0);
    end
    prev_stall    = !rst && valid_out_dfx && !tx_tready;
    prev_data     = data_out_dfx;
    prev_eof_xfer = !rst && valid_out_dfx && tx_tready && data_out_dfx[2];
    prev_done     = !rst && done_encap_pkt;
  end

  task automatic wait_accept(input int a0);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (acc_cnt == a0 && n < 60);
    check("accept_timeout", 64'(acc_cnt != a0), 64'd1);
  endtask

  task automatic send_pkt(input logic [DW-1:0] w, input bit rnd);
    int a0 = acc_cnt;
    int d0 = done_cnt;
    int n = 0;
    @(posedge clk); #1;
    data_dfx_send  = w;
    valid_dfx_send = 1'b1;
    wait_accept(a0);
    valid_dfx_send = 1'b0;
    data_dfx_send  = ~w;
    while (done_cnt == d0 && n < 400) begin
      tx_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    tx_tready = 1'b1;
    check("done_timeout", 64'(done_cnt != d0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] wa, wb;
    int c1, c2, d0, x0, n;
    ones = '1;

    // Reset behaviour
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ready_dfx_send), 64'd1);
    check("rst_valid", 64'(valid_out_dfx), 64'd0);
    check("rst_data", data_out_dfx, 64'd0);
    check("rst_done", 64'(done_encap_pkt), 64'd0);

    // All-ones word, no back-pressure
    send_pkt(ones, 1'b0);
    check("first_frame_lat", 64'(sof_cyc - acc_cyc), 64'd1);
    check("sof_hdr", 64'(sof_hdr), 64'h008);
`ifdef ENCAP_PARITY_EN
    check("eof_hdr", 64'(eof_hdr), 64'h125);
`else
    check("eof_hdr", 64'(eof_hdr), 64'h124);
`endif
    check("burst_len", 64'(eof_cyc - sof_cyc), 64'd18);
    check("done_lat", 64'(done_cyc - eof_cyc), 64'd1);

    // Random words with random back-pressure
    for (int p = 0; p < 3; p++) send_pkt(rand_word(), 1'b1);

    // Back-to-back with valid held high
    wa = rand_word();
    wb = rand_word();
    d0 = done_cnt;
    @(posedge clk); #1;
    data_dfx_send  = wa;
    valid_dfx_send = 1'b1;
    wait_accept(acc_cnt);
    c1 = acc_cyc;
    data_dfx_send = wb;
    wait_accept(acc_cnt);
    c2 = acc_cyc;
    valid_dfx_send = 1'b0;
    check("b2b_spacing", 64'(c2 - c1), 64'd21);
    n = 0;
    while (done_cnt < d0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
    check("b2b_done_count", 64'(done_cnt - d0), 64'd2);

    // Reset while frame 7 is on the link
    d0 = done_cnt;
    x0 = xfer_cnt;
    @(posedge clk); #1;
    data_dfx_send  = rand_word();
    valid_dfx_send = 1'b1;
    wait_accept(acc_cnt);
    valid_dfx_send = 1'b0;
    n = 0;
    while (xfer_cnt < x0 + 7 && n < 50) begin @(posedge clk); #1; n++; end
    check("abort_reached_f7", 64'(xfer_cnt - x0), 64'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    sent_q.delete();
    @(negedge clk);
    check("abort_valid", 64'(valid_out_dfx), 64'd0);
    check("abort_ready", 64'(ready_dfx_send), 64'd1);
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    send_pkt(rand_word(), 1'b0);
    check("restart_sof", 64'(sof_hdr[8:3]), 64'h01);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
